// File: rtl/pm_pkg.sv
// Shared types and default sizing for the program memory block.
package pm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} pm_state_t;
  localparam int PM_DATA_W = 16;
  localparam int PM_DEPTH  = 32;
endpackage

// File: rtl/pm_storage.sv
// Instruction storage array with per-word written flags.
// Define PM_PARITY_EN to keep an even-parity bit per word and check it on read.
module pm_storage
  import pm_pkg::*;
#(
  parameter int DATA_W = PM_DATA_W,
  parameter int DEPTH  = PM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_written_o,
  output logic              rd_perr_o
);
`ifdef PM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  wflag_q;
  logic [WORD_W-1:0] wr_word, rd_word;

  // Array contents are never reset; validity lives only in the flags.
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_addr_i] <= wr_word;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       wflag_q <= '0;
    else if (clr_i)   wflag_q <= '0;
    else if (wr_en_i) wflag_q[wr_addr_i] <= 1'b1;

  assign rd_word      = mem_q[rd_addr_i];
  assign rd_data_o    = rd_word[DATA_W-1:0];
  assign rd_written_o = wflag_q[rd_addr_i];

`ifdef PM_PARITY_EN
  assign wr_word   = {^wr_data_i, wr_data_i};
  assign rd_perr_o = rd_written_o & (^rd_word);
`else
  assign wr_word   = wr_data_i;
  assign rd_perr_o = 1'b0;
`endif
endmodule

// File: rtl/program_memory_v2.sv
// Loadable program memory: IDLE/LOAD/RUN control, load pointer, one-cycle fetch pipe.
// Optional parity checking is enabled by defining PM_PARITY_EN.
module program_memory_v2
  import pm_pkg::*;
#(
  parameter int DATA_W = PM_DATA_W,
  parameter int DEPTH  = PM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic [ADDR_W:0]   load_count
);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  pm_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              fv_q, fe_q;
  logic [DATA_W-1:0] fd_q;
  logic              clr, wr_en, fetch_acc, fetch_oor;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_written, rd_perr;

  assign load_ready  = (state_q == LOAD);
  assign fetch_ready = (state_q == RUN);
  assign fetch_acc   = fetch_req && fetch_ready;
  assign fetch_oor   = {1'b0, fetch_addr} >= DEPTH_L;
  assign rd_addr     = fetch_oor ? '0 : fetch_addr;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE, RUN: if (load_start) begin
        state_d  = LOAD;
        wr_ptr_d = '0;
        cnt_d    = '0;
        clr      = 1'b1;
      end
      LOAD: if (load_valid) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (load_last || wr_ptr_q == LAST_A) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch samples storage before this edge's flag clear, so a coincident
  // load_start still returns the old program word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      fd_q     <= '0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      fv_q     <= fetch_acc;
      if (fetch_acc) begin
        fd_q <= (fetch_oor || !rd_written) ? '0 : rd_data;
        fe_q <= fetch_oor || rd_perr;
      end
    end

  pm_storage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_storage (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_ptr_q),
    .wr_data_i    (load_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_written_o (rd_written),
    .rd_perr_o    (rd_perr)
  );

  assign fetch_valid = fv_q;
  assign fetch_data  = fd_q;
  assign fetch_err   = fe_q;
  assign load_count  = cnt_q;
endmodule

// File: doc/program_memory_v2.md
PROGRAM_MEMORY_V2 -- requirements
Module: program_memory_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of instruction words; legal range 2..1024, any value.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning address width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port load_start  input  1  meaning a one-cycle pulse that begins a program load.
REQ-007 SHALL have port load_valid  input  1  meaning load_data is valid this cycle.
REQ-008 SHALL have port load_data  input  DATA_W  meaning the next instruction word to store.
REQ-009 SHALL have port load_last  input  1  meaning the current load word is the final one.
REQ-010 SHALL have port load_ready  output  1  meaning a load word is accepted this cycle.
REQ-011 SHALL have port fetch_req  input  1  meaning a fetch is requested this cycle.
REQ-012 SHALL have port fetch_addr  input  ADDR_W  meaning the fetch word address.
REQ-013 SHALL have port fetch_ready  output  1  meaning the block accepts fetches.
REQ-014 SHALL have port fetch_valid  output  1  meaning fetch_data is valid.
REQ-015 SHALL have port fetch_data  output  DATA_W  meaning the fetched instruction.
REQ-016 SHALL have port fetch_err  output  1  meaning the accepted fetch was out of range, or had a parity fault.
REQ-017 SHALL have port load_count  output  ADDR_W+1  meaning the number of words written by the last load.

Function
REQ-018 SHALL implement states IDLE, LOAD and RUN.
REQ-019 SHALL make the transitions IDLE->LOAD and RUN->LOAD on load_start, LOAD->RUN on an accepted word with load_last, and LOAD->RUN on the accepted word at address DEPTH-1.
REQ-020 SHALL ignore load_start while in LOAD.
REQ-021 SHALL drive load_ready = (state==LOAD) and fetch_ready = (state==RUN).
REQ-022 SHALL, in LOAD, write load_data to address wr_ptr when load_valid && load_ready, then increment wr_ptr and load_count.
REQ-023 SHALL, on load_start, zero wr_ptr and load_count and clear every per-word written flag.
REQ-024 SHALL, in RUN, accept a fetch when fetch_req is high; fetch_valid is high exactly one cycle later, for one cycle (one-cycle registered latency, one fetch per cycle, fully pipelined).
REQ-025 SHALL return fetch_data = 0 for a word whose written flag is clear.
REQ-026 SHALL return fetch_data = 0 with fetch_err=1 when fetch_addr >= DEPTH.
REQ-027 SHALL hold fetch_err at 0 for every other fetch, except as given in REQ-034.
REQ-028 SHALL drop fetch_req when fetch_ready is low: no fetch_valid pulse results.
REQ-029 SHALL, when fetch_req and load_start coincide in RUN, complete the fetch with the pre-clear contents and enter LOAD on the same edge.
REQ-030 SHALL hold fetch_data at its last value while fetch_valid is low.

Reset
REQ-031 SHALL, on rst_n low and asynchronously, set state=IDLE, wr_ptr=0, load_count=0, fetch_valid=0, fetch_data=0, fetch_err=0 and clear all written flags; the storage array itself is not reset.
REQ-032 SHALL abandon a load interrupted by reset; words already written are treated as unwritten.

Configuration
REQ-033 SHALL, without PM_PARITY_EN, store DATA_W bits per word and perform no parity check.
REQ-034 SHALL, with PM_PARITY_EN defined, store one extra even-parity bit per word on write and check it on fetch; a mismatch sets fetch_err=1 and returns the stored data unchanged.

Structure
REQ-035 SHALL define the state enum pm_state_t and the default DATA_W and DEPTH constants in the shared package pm_pkg.
REQ-036 SHALL place the storage array, written flags and optional parity in the sub-module pm_storage; program_memory_v2 holds the FSM, the pointers and the fetch pipeline register.

Verification
REQ-037 SHALL be verified by this scenario: reset, load 0x0A01 then 0x0B22 with load_last -> RUN, load_count=2, fetch 0 -> next cycle 0x0A01, fetch 1 -> 0x0B22.
REQ-038 SHALL be verified by this scenario: after that load, fetch address 31 -> fetch_data=0 and fetch_err=0.
REQ-039 SHALL be verified by this scenario: DEPTH=20, fetch address 25 -> fetch_data=0 and fetch_err=1.
REQ-040 SHALL be verified by this scenario: load 32 words without load_last -> RUN after word 31, load_count=32, then back-to-back fetches 0..31 -> one valid per cycle, correct data.
REQ-041 SHALL be verified by this scenario: fetch_req in IDLE -> no fetch_valid; rst_n low mid-load -> IDLE, and a subsequent load and fetch of an earlier address -> 0.
REQ-042 SHALL be verified by this scenario: with PM_PARITY_EN, force a stored bit flip -> fetch_err=1 on that fetch.
